// File: rtl/fpu_stream_driver.sv
// ============================================================================
// FpuStreamDriver (module fpu_stream_driver)
//
// Purpose:
//    Master-side driver for a 16-bit stb/ack FPU operand/result protocol.
//    It takes a 32-bit operand pair from a valid/ready command port and sends
//    operand A to the FPU as a hi word then a lo word. It then sends operand B
//    the same way. It collects the 32-bit result as hi/lo words and presents
//    it on a valid/ready result port. Only one operation is in flight at a
//    time. Every output is driven straight from a register.
//
// Parameters:
//    CNT_W           width of the completed-operation counter op_count
//    TIMEOUT_CYCLES  cycles without a handshake before an abort
//                    (this parameter exists only when FPU_DRV_TIMEOUT_EN is defined)
//
// Ports:
//    clk, rst               clock (posedge) and synchronous active-high reset
//    cmd_a, cmd_b           operand pair (IEEE-754 single)
//    cmd_valid, cmd_ready   command handshake
//    res_z                  result word
//    res_valid, res_ready   result handshake
//    fpu_a, fpu_a_stb/ack   operand A word channel to the FPU
//    fpu_b, fpu_b_stb/ack   operand B word channel to the FPU
//    fpu_z, fpu_z_stb/ack   result word channel from the FPU
//    op_count               completed operations, wraps modulo 2^CNT_W
//    err                    sticky timeout flag
//
// Build option:
//    FPU_DRV_TIMEOUT_EN  When defined, a per-state watchdog aborts an operation
//                        that stalls in a SEND/RECV state and sets err. When not
//                        defined, err is tied low and the driver waits forever.
// ============================================================================
module fpu_stream_driver #(
   parameter int CNT_W = 16
`ifdef FPU_DRV_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic [31:0]      res_z,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      fpu_a,
   output logic             fpu_a_stb,
   input  logic             fpu_a_ack,
   output logic [15:0]      fpu_b,
   output logic             fpu_b_stb,
   input  logic             fpu_b_ack,
   input  logic [15:0]      fpu_z,
   input  logic             fpu_z_stb,
   output logic             fpu_z_ack,
   output logic [CNT_W-1:0] op_count,
   output logic             err
);

   typedef enum logic [2:0] {
      IDLE,
      SEND_A_HI,
      SEND_A_LO,
      SEND_B_HI,
      SEND_B_LO,
      RECV_Z_HI,
      RECV_Z_LO,
      RESULT
   } state_t;

   state_t state_q, state_d;

   // The A hi word goes straight from cmd_a to the fpu_a register when the
   // command is accepted. Only the A lo word has to be kept. All of B is kept.
   logic [15:0]      opALo_q, opALo_d;
   logic [31:0]      opB_q, opB_d;
   logic             cmdReady_q, cmdReady_d;
   logic [31:0]      resZ_q, resZ_d;
   logic             resValid_q, resValid_d;
   logic [15:0]      fpuA_q, fpuA_d;
   logic             fpuAStb_q, fpuAStb_d;
   logic [15:0]      fpuB_q, fpuB_d;
   logic             fpuBStb_q, fpuBStb_d;
   logic             fpuZAck_q, fpuZAck_d;
   logic [CNT_W-1:0] opCount_q, opCount_d;
   logic             xfer;

`ifdef FPU_DRV_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] toCnt_q, toCnt_d;
   logic            err_q, err_d;
   logic            inWait;

   // The watchdog counter and the sticky error flag share the same
   // synchronous reset as the rest of the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         toCnt_q <= '0;
         err_q   <= 1'b0;
      end else begin
         toCnt_q <= toCnt_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State and output registers. Reset returns to IDLE immediately, even in
   // the middle of an operation. No partially sent words are reissued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         opALo_q    <= '0;
         opB_q      <= '0;
         cmdReady_q <= 1'b1;
         resZ_q     <= '0;
         resValid_q <= 1'b0;
         fpuA_q     <= '0;
         fpuAStb_q  <= 1'b0;
         fpuB_q     <= '0;
         fpuBStb_q  <= 1'b0;
         fpuZAck_q  <= 1'b0;
         opCount_q  <= '0;
      end else begin
         state_q    <= state_d;
         opALo_q    <= opALo_d;
         opB_q      <= opB_d;
         cmdReady_q <= cmdReady_d;
         resZ_q     <= resZ_d;
         resValid_q <= resValid_d;
         fpuA_q     <= fpuA_d;
         fpuAStb_q  <= fpuAStb_d;
         fpuB_q     <= fpuB_d;
         fpuBStb_q  <= fpuBStb_d;
         fpuZAck_q  <= fpuZAck_d;
         opCount_q  <= opCount_d;
      end
   end

   // Next-state and next-output logic. Each SEND/RECV state moves on only when
   // its own channel completes a transfer (stb and ack both high). The word
   // registers change only on a transfer. This keeps the data stable for as
   // long as the strobe is waiting for an ack. The stb/ack bits are updated
   // in the same step that advances the state, so they always line up with
   // the state that is currently being served.
   always_comb begin
      state_d    = state_q;
      opALo_d    = opALo_q;
      opB_d      = opB_q;
      cmdReady_d = cmdReady_q;
      resZ_d     = resZ_q;
      resValid_d = resValid_q;
      fpuA_d     = fpuA_q;
      fpuAStb_d  = fpuAStb_q;
      fpuB_d     = fpuB_q;
      fpuBStb_d  = fpuBStb_q;
      fpuZAck_d  = fpuZAck_q;
      opCount_d  = opCount_q;
      xfer       = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmdReady_q) begin
               opALo_d    = cmd_a[15:0];
               opB_d      = cmd_b;
               cmdReady_d = 1'b0;
               fpuA_d     = cmd_a[31:16];
               fpuAStb_d  = 1'b1;
               state_d    = SEND_A_HI;
            end
         end
         SEND_A_HI: begin
            xfer = fpuAStb_q && fpu_a_ack;
            if (xfer) begin
               fpuA_d  = opALo_q;
               state_d = SEND_A_LO;
            end
         end
         SEND_A_LO: begin
            xfer = fpuAStb_q && fpu_a_ack;
            if (xfer) begin
               fpuAStb_d = 1'b0;
               fpuB_d    = opB_q[31:16];
               fpuBStb_d = 1'b1;
               state_d   = SEND_B_HI;
            end
         end
         SEND_B_HI: begin
            xfer = fpuBStb_q && fpu_b_ack;
            if (xfer) begin
               fpuB_d  = opB_q[15:0];
               state_d = SEND_B_LO;
            end
         end
         SEND_B_LO: begin
            xfer = fpuBStb_q && fpu_b_ack;
            if (xfer) begin
               fpuBStb_d = 1'b0;
               fpuZAck_d = 1'b1;
               state_d   = RECV_Z_HI;
            end
         end
         RECV_Z_HI: begin
            xfer = fpu_z_stb && fpuZAck_q;
            if (xfer) begin
               resZ_d[31:16] = fpu_z;
               state_d       = RECV_Z_LO;
            end
         end
         RECV_Z_LO: begin
            xfer = fpu_z_stb && fpuZAck_q;
            if (xfer) begin
               resZ_d[15:0] = fpu_z;
               fpuZAck_d    = 1'b0;
               resValid_d   = 1'b1;
               opCount_d    = opCount_q + CNT_W'(1);
               state_d      = RESULT;
            end
         end
         RESULT: begin
            if (resValid_q && res_ready) begin
               resValid_d = 1'b0;
               cmdReady_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef FPU_DRV_TIMEOUT_EN
      // The watchdog counts cycles spent in a SEND/RECV state and restarts on
      // every state change. If it reaches the limit without a transfer, the
      // operation is dropped with no result and no count change. The FPU is
      // left for the host to reset.
      err_d   = err_q;
      inWait  = (state_q != IDLE) && (state_q != RESULT);
      toCnt_d = '0;
      if (inWait && (state_d == state_q)) begin
         toCnt_d = toCnt_q + TO_W'(1);
      end
      if (inWait && !xfer && (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
         err_d      = 1'b1;
         fpuAStb_d  = 1'b0;
         fpuBStb_d  = 1'b0;
         fpuZAck_d  = 1'b0;
         cmdReady_d = 1'b1;
         state_d    = IDLE;
         toCnt_d    = '0;
      end
`endif
   end

   assign cmd_ready = cmdReady_q;
   assign res_z     = resZ_q;
   assign res_valid = resValid_q;
   assign fpu_a     = fpuA_q;
   assign fpu_a_stb = fpuAStb_q;
   assign fpu_b     = fpuB_q;
   assign fpu_b_stb = fpuBStb_q;
   assign fpu_z_ack = fpuZAck_q;
   assign op_count  = opCount_q;

endmodule

// File: tb/tb_fpu_stream_driver.sv
// ============================================================================
// TbFpuStreamDriver (module tb_fpu_stream_driver)
//
// Purpose:
//    Self-checking bench for fpu_stream_driver with CNT_W = 2, so op_count
//    wraps after a few operations. A behavioural FPU responds on the word
//    channels with randomized ack/stb delays. It checks each received operand
//    word against what the host sent and checks that the data stays stable
//    while its strobe waits for an ack. It then returns the sum from a
//    truncating single-precision adder. The host side applies a table of
//    known float sums, a run of random operations, and hand-written
//    sequences for reset in the middle of an operation and (with
//    FPU_DRV_TIMEOUT_EN) the watchdog abort.
// ============================================================================
module tb_fpu_stream_driver;

   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic [31:0]      cmd_a, cmd_b;
   logic             cmd_valid, cmd_ready;
   logic [31:0]      res_z;
   logic             res_valid, res_ready;
   logic [15:0]      fpu_a, fpu_b, fpu_z;
   logic             fpu_a_stb, fpu_a_ack, fpu_b_stb, fpu_b_ack;
   logic             fpu_z_stb, fpu_z_ack;
   logic [CNT_W-1:0] op_count;
   logic             err;

   int checks   = 0;
   int failures = 0;
   int opsDone  = 0;

   // FPU model controls. When modelOn is low, the acks come from the manual
   // signals that the hand-written sequences drive.
   bit  modelOn = 1'b1;
   bit  noiseOn = 1'b0;
   int  maxDelay = 0;
   logic manA = 1'b0, manB = 1'b0;
   logic modelAAck = 1'b0, modelBAck = 1'b0, modelZStb = 1'b0;

   logic [15:0] expAQ[$], expBQ[$], zQ[$];

   assign fpu_a_ack = modelOn ? modelAAck : manA;
   assign fpu_b_ack = modelOn ? modelBAck : manB;
   assign fpu_z_stb = modelOn ? modelZStb : 1'b0;

   fpu_stream_driver #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .res_z     (res_z),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .fpu_a     (fpu_a),
      .fpu_a_stb (fpu_a_stb),
      .fpu_a_ack (fpu_a_ack),
      .fpu_b     (fpu_b),
      .fpu_b_stb (fpu_b_stb),
      .fpu_b_ack (fpu_b_ack),
      .fpu_z     (fpu_z),
      .fpu_z_stb (fpu_z_stb),
      .fpu_z_ack (fpu_z_ack),
      .op_count  (op_count),
      .err       (err)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run goes wrong in a way that the bounded waits
   // do not catch.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s", name);
   endtask

   // Truncating single-precision adder for positive normal operands.
   function automatic logic [31:0] addf(input logic [31:0] x, input logic [31:0] y);
      logic [7:0]  ex, ey, e;
      logic [24:0] mx, my, s, tm;
      int          d;
      ex = x[30:23];
      ey = y[30:23];
      mx = {2'b01, x[22:0]};
      my = {2'b01, y[22:0]};
      if (ey > ex) begin
         e  = ex; ex = ey; ey = e;
         tm = mx; mx = my; my = tm;
      end
      d  = int'(ex) - int'(ey);
      my = (d > 24) ? 25'd0 : (my >> d);
      s  = mx + my;
      e  = ex;
      if (s[24]) begin
         s = s >> 1;
         e = e + 8'd1;
      end
      return {1'b0, e, s[22:0]};
   endfunction

   // Behavioural FPU. It acts on falling edges, so the ack or strobe it
   // drives is settled before the next rising edge. The register outputs it
   // reads have been stable since the last rising edge. Setting an ack here
   // while the strobe is high means a transfer happens on the coming edge,
   // so the word is recorded at that moment.
   initial begin : fpuModel
      int aDelay = -1, bDelay = -1, zDelay = -1;
      int bWords = 0;
      logic [15:0] aHeld = '0, bHeld = '0;
      logic [31:0] rxA = '0, rxB = '0, z;
      fpu_z = '0;
      forever begin
         @(negedge clk);
         if (!modelOn) begin
            modelAAck = 1'b0; modelBAck = 1'b0; modelZStb = 1'b0;
            aDelay = -1; bDelay = -1; zDelay = -1;
         end else begin
            if (fpu_a_stb) begin
               if (aDelay < 0) begin
                  aDelay = int'($urandom_range(0, maxDelay));
                  aHeld  = fpu_a;
               end else begin
                  checkOutput("fpu_a_stable", {16'd0, fpu_a}, {16'd0, aHeld});
               end
               if (aDelay == 0) begin
                  modelAAck = 1'b1;
                  aDelay    = -1;
                  if (expAQ.size() == 0) reportFail("fpu_a_unexpected_word");
                  else checkOutput("fpu_a_word", {16'd0, fpu_a}, {16'd0, expAQ.pop_front()});
                  rxA = {rxA[15:0], fpu_a};
               end else begin
                  modelAAck = 1'b0;
                  aDelay--;
               end
            end else begin
               modelAAck = 1'b0;
               aDelay    = -1;
            end

            if (fpu_b_stb) begin
               if (bDelay < 0) begin
                  bDelay = int'($urandom_range(0, maxDelay));
                  bHeld  = fpu_b;
               end else begin
                  checkOutput("fpu_b_stable", {16'd0, fpu_b}, {16'd0, bHeld});
               end
               if (bDelay == 0) begin
                  modelBAck = 1'b1;
                  bDelay    = -1;
                  if (expBQ.size() == 0) reportFail("fpu_b_unexpected_word");
                  else checkOutput("fpu_b_word", {16'd0, fpu_b}, {16'd0, expBQ.pop_front()});
                  rxB = {rxB[15:0], fpu_b};
                  bWords++;
                  if (bWords == 2) begin
                     bWords = 0;
                     z = addf(rxA, rxB);
                     zQ.push_back(z[31:16]);
                     zQ.push_back(z[15:0]);
                  end
               end else begin
                  modelBAck = 1'b0;
                  bDelay--;
               end
            end else begin
               modelBAck = 1'b0;
               bDelay    = -1;
            end

            if (zQ.size() > 0) begin
               if (zDelay < 0) zDelay = int'($urandom_range(0, maxDelay));
               if (zDelay == 0) begin
                  modelZStb = 1'b1;
                  fpu_z     = zQ[0];
                  if (fpu_z_ack) begin
                     void'(zQ.pop_front());
                     zDelay = -1;
                  end
               end else begin
                  modelZStb = 1'b0;
                  zDelay--;
               end
            end else if (noiseOn && !fpu_z_ack) begin
               modelZStb = 1'($urandom_range(0, 1));
               fpu_z     = 16'($urandom);
            end else begin
               modelZStb = 1'b0;
            end
         end
      end
   end

   // Runs one full operation from the host side. It checks that the command
   // is accepted, the result value, op_count, the latency (when requested),
   // and that the result stays stable while res_ready is held low. It also
   // checks that a command offered during RESULT is not taken.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expZ,
                                input logic [CNT_W-1:0] expCnt, input int readyDelay, input bit checkLat);
      int w;
      cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         reportFail("cmd_accept_timeout");
         cmd_valid = 1'b0;
         return;
      end
      expAQ.push_back(a[31:16]); expAQ.push_back(a[15:0]);
      expBQ.push_back(b[31:16]); expBQ.push_back(b[15:0]);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_a = $urandom; cmd_b = $urandom;
      checkOutput("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      w = 1;
      while (!res_valid && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!res_valid) begin
         reportFail("res_valid_timeout");
         return;
      end
      // Accept edge to res_valid edge is six clocks. That is seven falling
      // edges, counted from the falling edge where the command was offered.
      if (checkLat) checkOutput("latency", w, 32'd7);
      checkOutput("res_z", res_z, expZ);
      checkOutput("op_count", {30'd0, op_count}, {30'd0, expCnt});
      for (int i = 0; i < readyDelay; i++) begin
         cmd_valid = 1'b1;
         @(negedge clk);
         checkOutput("res_z_hold", res_z, expZ);
         checkOutput("res_valid_hold", {31'd0, res_valid}, 32'd1);
         checkOutput("cmd_ready_hold", {31'd0, cmd_ready}, 32'd0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("res_valid_drop", {31'd0, res_valid}, 32'd0);
      checkOutput("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
   endtask

   typedef struct {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [31:0]      z;
      logic [CNT_W-1:0] cnt;
      int               readyDelay;
   } vec_t;

   vec_t vecs[5];

   initial begin : main
      logic [31:0] ra, rb;
      int w;

      // Known float sums, run back to back after reset. op_count for a
      // 2-bit counter goes 1,2,3,0,1. Entry 2 holds res_ready low for 20
      // cycles.
      vecs[0] = '{a: 32'h3F800000, b: 32'h40000000, z: 32'h40400000, cnt: 2'd1, readyDelay: 0};
      vecs[1] = '{a: 32'h3F800000, b: 32'h3F800000, z: 32'h40000000, cnt: 2'd2, readyDelay: 1};
      vecs[2] = '{a: 32'h3FC00000, b: 32'h40200000, z: 32'h40800000, cnt: 2'd3, readyDelay: 20};
      vecs[3] = '{a: 32'h3F000000, b: 32'h3E800000, z: 32'h3F400000, cnt: 2'd0, readyDelay: 0};
      vecs[4] = '{a: 32'h41200000, b: 32'h3F000000, z: 32'h41280000, cnt: 2'd1, readyDelay: 2};

      rst = 1'b1; cmd_a = '0; cmd_b = '0; cmd_valid = 1'b0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("rst_res_z", res_z, 32'd0);
      checkOutput("rst_fpu_a", {16'd0, fpu_a}, 32'd0);
      checkOutput("rst_fpu_b", {16'd0, fpu_b}, 32'd0);
      checkOutput("rst_fpu_a_stb", {31'd0, fpu_a_stb}, 32'd0);
      checkOutput("rst_fpu_b_stb", {31'd0, fpu_b_stb}, 32'd0);
      checkOutput("rst_fpu_z_ack", {31'd0, fpu_z_ack}, 32'd0);
      checkOutput("rst_op_count", {30'd0, op_count}, 32'd0);
      checkOutput("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;

      $display("[TB] reset during SEND_B_LO");
      @(negedge clk);
      modelOn = 1'b0; manA = 1'b0; manB = 1'b0;
      cmd_a = 32'h12345678; cmd_b = 32'h9ABCDEF0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("man_a_stb", {31'd0, fpu_a_stb}, 32'd1);
      checkOutput("man_a_hi", {16'd0, fpu_a}, 32'h1234);
      @(negedge clk);
      checkOutput("man_a_hi_stable", {16'd0, fpu_a}, 32'h1234);
      manA = 1'b1;
      @(negedge clk);
      checkOutput("man_a_lo", {16'd0, fpu_a}, 32'h5678);
      @(negedge clk);
      manA = 1'b0; manB = 1'b1;
      checkOutput("man_a_stb_drop", {31'd0, fpu_a_stb}, 32'd0);
      checkOutput("man_b_hi", {16'd0, fpu_b}, 32'h9ABC);
      @(negedge clk);
      manB = 1'b0;
      checkOutput("man_b_lo", {16'd0, fpu_b}, 32'hDEF0);
      checkOutput("man_b_stb", {31'd0, fpu_b_stb}, 32'd1);
      checkOutput("man_z_ack_low", {31'd0, fpu_z_ack}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_a_stb", {31'd0, fpu_a_stb}, 32'd0);
      checkOutput("midrst_b_stb", {31'd0, fpu_b_stb}, 32'd0);
      checkOutput("midrst_z_ack", {31'd0, fpu_z_ack}, 32'd0);
      checkOutput("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("midrst_res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("midrst_op_count", {30'd0, op_count}, 32'd0);
      @(negedge clk);
      modelOn = 1'b1;

      $display("[TB] directed float vectors, zero-delay FPU");
      maxDelay = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].cnt, vecs[i].readyDelay, 1'b1);
         opsDone++;
      end

      $display("[TB] random operands, random FPU delays 0-5");
      maxDelay = 5;
      noiseOn  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ra = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
         rb = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
         opsDone++;
         applyStimulus(ra, rb, addf(ra, rb), CNT_W'(opsDone), int'($urandom_range(0, 3)), 1'b0);
      end
      noiseOn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("model_queues_empty", expAQ.size() + expBQ.size() + zQ.size(), 32'd0);

`ifdef FPU_DRV_TIMEOUT_EN
      $display("[TB] watchdog abort with fpu_b_ack held low");
      modelOn = 1'b0; manA = 1'b0; manB = 1'b0;
      cmd_a = 32'h3F800000; cmd_b = 32'h40000000; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0; manA = 1'b1;
      @(negedge clk);
      @(negedge clk);
      manA = 1'b0;
      w = 0;
      while (!err && w < 1100) begin
         @(negedge clk);
         w++;
      end
      checkOutput("to_err", {31'd0, err}, 32'd1);
      checkOutput("to_b_stb", {31'd0, fpu_b_stb}, 32'd0);
      checkOutput("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("to_res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("to_op_count", {30'd0, op_count}, {30'd0, CNT_W'(opsDone)});
`else
      w = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
